// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and default width
// for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_e;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of unsigned shift-add
// multiply (div_i=0) or restoring divide (div_i=1).
// Ports: div_i mode, acc_i/acc_o {upper,lower} accumulator,
// opb_i multiplicand or divisor.
module muldiv_step #(
   parameter int W = 32
) (
   input  logic           div_i,
   input  logic [2*W-1:0] acc_i,
   input  logic [W-1:0]   opb_i,
   output logic [2*W-1:0] acc_o
);

   logic [W:0] sum;
   logic [W:0] shl;
   logic [W:0] trial;

   always_comb begin
      // mul: low half holds the remaining multiplier bits
      sum   = {1'b0, acc_i[2*W-1:W]}
            + (acc_i[0] ? {1'b0, opb_i} : '0);
      // div: remainder shifted left with next dividend bit
      shl   = {acc_i[2*W-1:W], acc_i[W-1]};
      trial = shl - {1'b0, opb_i};
      if (div_i) begin
         if (trial[W])
            acc_o = {shl[W-1:0], acc_i[W-2:0], 1'b0};
         else
            acc_o = {trial[W-1:0], acc_i[W-2:0], 1'b1};
      end else begin
         acc_o = {sum, acc_i[W-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Ports: op_valid/op/DataA/DataB/flush in; busy, stall, done,
// hi, lo, rd_data (MFHI/MFLO read, combinational) out.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] DataA,
   input  logic [WIDTH-1:0] DataB,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rd_data
);

   localparam int CW = $clog2(WIDTH);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, step;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic                 qneg_q, qneg_d;
   logic                 rneg_q, rneg_d;
   logic                 div_q, div_d;
   logic                 done_q, done_d;

   logic                 accept, op_div, op_sgn;
   logic                 a_neg, b_neg, dz;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH-1:0]     fix_q, fix_r;
   logic [2*WIDTH-1:0]   fix_p;

   muldiv_step #(.W(WIDTH)) u_step (
      .div_i (div_q),
      .acc_i (acc_q),
      .opb_i (opb_q),
      .acc_o (step)
   );

   assign accept = (state_q == S_IDLE) & op_valid
                 & ~flush & is_muldiv(op);
   assign op_div = (op == OP_DIV) | (op == OP_DIVU);
   assign op_sgn = (op == OP_MULT) | (op == OP_DIV);
   assign a_neg  = op_sgn & DataA[WIDTH-1];
   assign b_neg  = op_sgn & DataB[WIDTH-1];
   assign a_abs  = a_neg ? -DataA : DataA;
   assign b_abs  = b_neg ? -DataB : DataB;
   assign dz     = op_div & (DataB == '0);

   // remainder follows dividend sign, quotient/product the xor
   assign fix_p  = qneg_q ? -acc_q : acc_q;
   assign fix_q  = qneg_q ? -acc_q[WIDTH-1:0]
                          : acc_q[WIDTH-1:0];
   assign fix_r  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                          : acc_q[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: if (accept)
               state_d = dz     ? S_FIX :
                         op_div ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (cnt_q == '0)
               state_d = S_FIX;
            S_FIX: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy    = (state_q != S_IDLE);
      stall   = op_valid & busy
              & (op != OP_NOP) & (op <= OP_MTLO);
      rd_data = '0;
      if (op == OP_MFHI)      rd_data = hi_q;
      else if (op == OP_MFLO) rd_data = lo_q;
      done    = done_q;
      hi      = hi_q;
      lo      = lo_q;
   end

   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      opb_d  = opb_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      div_d  = div_q;
      done_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d = CW'(WIDTH - 1);
               opb_d = b_abs;
               div_d = op_div;
               if (dz) begin
                  acc_d  = {DataA, {WIDTH{1'b1}}};
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, a_abs};
                  qneg_d = a_neg ^ b_neg;
                  rneg_d = a_neg;
               end
            end else if (op_valid & ~flush) begin
               if (op == OP_MTHI) hi_d = DataA;
               if (op == OP_MTLO) lo_d = DataA;
            end
         end
         S_MUL, S_DIV: begin
            acc_d = step;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         end
         S_FIX: begin
            if (!flush) begin
               if (div_q) {hi_d, lo_d} = {fix_r, fix_q};
               else       {hi_d, lo_d} = fix_p;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         opb_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         div_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         opb_q  <= opb_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         div_q  <= div_d;
         done_q <= done_d;
      end
   end

endmodule
